// File: rtl/hdmi_src_switch_ctrl_pkg.sv
// Shared types for the HDMI source-switch sequencer: state codes, the
// registered control-output bundle, and the per-state output decode.
package hdmi_src_switch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUTE      = 3'd1,
    ST_BLANK     = 3'd2,
    ST_PLL_RST   = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_UNMUTE    = 3'd6,
    ST_FAIL      = 3'd7
  } state_e;

  typedef struct packed {
    logic pll_rst;
    logic blank;
    logic audio_mute;
    logic busy;
  } ctrl_out_t;

  // Matches the PLL_RST state, which is where reset parks the FSM.
  localparam ctrl_out_t RST_OUT = '{pll_rst: 1'b1, blank: 1'b1, audio_mute: 1'b1, busy: 1'b1};

  function automatic ctrl_out_t state_outs(input state_e s);
    ctrl_out_t o;
    o = '{pll_rst: 1'b0, blank: 1'b1, audio_mute: 1'b1, busy: 1'b1};
    case (s)
      ST_IDLE: begin
        o.blank      = 1'b0;
        o.audio_mute = 1'b0;
        o.busy       = 1'b0;
      end
      ST_MUTE, ST_UNMUTE: o.blank   = 1'b0;
      ST_PLL_RST:         o.pll_rst = 1'b1;
      ST_FAIL:            o.busy    = 1'b0;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/hdmi_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module hdmi_sync_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hdmi_src_switch_ctrl.sv
// Sequences a glitch-free VGA/FT source switch: mute, blank, flip select,
// PLL reset + lock qualification with retries, frame settle, unblank, unmute.
module hdmi_src_switch_ctrl
  import hdmi_src_switch_ctrl_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_FILTER    = 64,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned SETTLE_FRAMES  = 2,
  parameter int unsigned VS_TIMEOUT     = 1048575,
  parameter logic        VS_ACTIVE      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sel_req,
  input  logic pll_locked,
  input  logic vsync,
  output logic src_sel,
  output logic pll_rst,
  output logic blank,
  output logic audio_mute,
  output logic busy,
  output logic lock_err
);

  localparam int unsigned TMR_MAX =
    (VS_TIMEOUT > LOCK_TIMEOUT) ? ((VS_TIMEOUT > PLL_RST_CYCLES) ? VS_TIMEOUT : PLL_RST_CYCLES)
                                : ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int LCK_W = $clog2(LOCK_FILTER + 1);
  localparam int FRM_W = $clog2(SETTLE_FRAMES + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [LCK_W-1:0] lck_q, lck_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [RTY_W-1:0] rty_q, rty_d, rty_inc;
  logic             src_sel_q, src_sel_d;
  logic             lock_err_q, lock_err_d;
  logic             vs_q;
  ctrl_out_t        outs_q, outs_d;

  logic sel_sync, lock_sync, vs_edge, vs_tmo, lock_ok, frame;

  hdmi_sync_bit u_sel_sync  (.clk(clk), .reset_n(reset_n), .d(sel_req),    .q(sel_sync));
  hdmi_sync_bit u_lock_sync (.clk(clk), .reset_n(reset_n), .d(pll_locked), .q(lock_sync));

  assign vs_edge = (vsync == VS_ACTIVE) && (vs_q != VS_ACTIVE);
  assign vs_tmo  = (tmr_q == TMR_W'(VS_TIMEOUT - 1));
  assign frame   = vs_edge || vs_tmo;
  assign lock_ok = lock_sync && (lck_q == LCK_W'(LOCK_FILTER - 1));
  assign rty_inc = rty_q + RTY_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PLL_RST;
      tmr_q      <= '0;
      lck_q      <= '0;
      frm_q      <= '0;
      rty_q      <= '0;
      src_sel_q  <= 1'b0;
      lock_err_q <= 1'b0;
      vs_q       <= ~VS_ACTIVE;
      outs_q     <= RST_OUT;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      lck_q      <= lck_d;
      frm_q      <= frm_d;
      rty_q      <= rty_d;
      src_sel_q  <= src_sel_d;
      lock_err_q <= lock_err_d;
      vs_q       <= vsync;
      outs_q     <= outs_d;
    end
  end

  // A pending source request always wins over lock-loss recovery.
  always_comb begin
    state_d    = state_q;
    rty_d      = rty_q;
    src_sel_d  = src_sel_q;
    lock_err_d = lock_err_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_sync != src_sel_q) state_d = ST_MUTE;
        else if (!lock_sync)       state_d = ST_BLANK;
      end
      ST_MUTE:   if (frame) state_d = ST_BLANK;
      ST_BLANK: begin
        src_sel_d = sel_sync;
        rty_d     = '0;
        state_d   = ST_PLL_RST;
      end
      ST_PLL_RST: if (tmr_q == TMR_W'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          state_d    = ST_SETTLE;
          lock_err_d = 1'b0;
        end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          rty_d = rty_inc;
          if (rty_inc < RTY_W'(MAX_RETRIES)) begin
            state_d = ST_PLL_RST;
          end else begin
            state_d    = ST_FAIL;
            lock_err_d = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (!lock_sync)                                         state_d = ST_PLL_RST;
        else if (frame && frm_q == FRM_W'(SETTLE_FRAMES - 1))   state_d = ST_UNMUTE;
      end
      ST_UNMUTE: if (frame) state_d = ST_IDLE;
      ST_FAIL: begin
        if (sel_sync != src_sel_q) begin
          state_d = ST_BLANK;
        end else if (lock_ok) begin
          state_d    = ST_SETTLE;
          lock_err_d = 1'b0;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
  end

  // Every counter restarts from zero whenever the state changes.
  always_comb begin
    tmr_d = '0;
    lck_d = '0;
    frm_d = frm_q;
    if (state_d != state_q) begin
      frm_d = '0;
    end else begin
      case (state_q)
        ST_MUTE, ST_PLL_RST, ST_WAIT_LOCK, ST_UNMUTE: tmr_d = tmr_q + TMR_W'(1);
        ST_SETTLE: begin
          if (frame) frm_d = frm_q + FRM_W'(1);
          else       tmr_d = tmr_q + TMR_W'(1);
        end
        default: ;
      endcase
      if (state_q == ST_WAIT_LOCK || state_q == ST_FAIL)
        lck_d = lock_sync ? lck_q + LCK_W'(1) : '0;
    end
  end

  always_comb begin
    outs_d = state_outs(state_d);
  end

  assign src_sel    = src_sel_q;
  assign pll_rst    = outs_q.pll_rst;
  assign blank      = outs_q.blank;
  assign audio_mute = outs_q.audio_mute;
  assign busy       = outs_q.busy;
  assign lock_err   = lock_err_q;

endmodule

// File: tb/tb_hdmi_src_switch_ctrl.sv
// Directed bench for the HDMI source-switch sequencer with small timing parameters.
module tb_hdmi_src_switch_ctrl;

  logic clk = 1'b0;
  logic reset_n, sel_req, pll_locked, vsync;
  logic src_sel, pll_rst, blank, audio_mute, busy, lock_err;
  bit   vs_en = 1'b0;
  int   vcnt = 0;
  int   n_rise = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // vsync: period 200 cycles, high for 10; restarting vs_en restarts the phase.
  always @(negedge clk) begin
    if (!vs_en) vcnt <= 0;
    else        vcnt <= (vcnt == 199) ? 0 : vcnt + 1;
    if (vs_en && vcnt == 99) n_rise <= n_rise + 1;
  end
  assign vsync = vs_en && (vcnt >= 100) && (vcnt < 110);

  hdmi_src_switch_ctrl #(
    .PLL_RST_CYCLES(4), .LOCK_FILTER(4), .LOCK_TIMEOUT(100), .MAX_RETRIES(2),
    .SETTLE_FRAMES(2), .VS_TIMEOUT(1000), .VS_ACTIVE(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel_req(sel_req), .pll_locked(pll_locked), .vsync(vsync),
    .src_sel(src_sel), .pll_rst(pll_rst), .blank(blank), .audio_mute(audio_mute),
    .busy(busy), .lock_err(lock_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur(input int w);
    case (w)
      0: return src_sel;
      1: return pll_rst;
      2: return blank;
      3: return audio_mute;
      4: return busy;
      default: return lock_err;
    endcase
  endfunction

  // Waits for an output to reach v; n = cycles waited, or -1 on timeout.
  task automatic wait_sig(input int w, input logic v, input int lim, output int n);
    n = 0;
    while (cur(w) !== v && n < lim) begin
      tick();
      n++;
    end
    if (cur(w) !== v) n = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sel_req = 1'b0; pll_locked = 1'b0; vs_en = 1'b0;
    repeat (3) tick();
    total++;
    if ({src_sel, pll_rst, blank, audio_mute, busy, lock_err} !== 6'b011110) begin
      bad++; $display("FAIL reset_outs got=%b exp=011110", {src_sel, pll_rst, blank, audio_mute, busy, lock_err});
    end
  endtask

  task automatic test_power_up();
    int n, r0;
    reset_n = 1'b1; vs_en = 1'b1; r0 = n_rise;
    n = 0;
    while (pll_rst && n < 50) begin n++; tick(); end
    total++; if (n !== 4) begin bad++; $display("FAIL pu_pll_rst_len got=%0d exp=4", n); end
    repeat (6) tick();
    pll_locked = 1'b1;
    wait_sig(2, 1'b0, 2000, n);
    total++; if (n < 0) begin bad++; $display("FAIL pu_blank_fall got=timeout exp=fall"); end
    total++; if (n_rise - r0 !== 2) begin bad++; $display("FAIL pu_frames_to_unblank got=%0d exp=2", n_rise - r0); end
    total++; if ({audio_mute, busy} !== 2'b11) begin bad++; $display("FAIL pu_unmute_phase got=%b exp=11", {audio_mute, busy}); end
    wait_sig(3, 1'b0, 400, n);
    total++; if (n !== 200) begin bad++; $display("FAIL pu_mute_after_blank got=%0d exp=200", n); end
    total++;
    if ({src_sel, pll_rst, blank, audio_mute, busy, lock_err} !== 6'b000000) begin
      bad++; $display("FAIL pu_idle_outs got=%b exp=000000", {src_sel, pll_rst, blank, audio_mute, busy, lock_err});
    end
  endtask

  task automatic test_switch();
    int n, r1;
    sel_req = 1'b1;
    repeat (2) tick();
    total++; if (audio_mute !== 1'b0) begin bad++; $display("FAIL sw_mute_early got=%b exp=0", audio_mute); end
    tick();
    total++; if ({audio_mute, busy, src_sel} !== 3'b110) begin bad++; $display("FAIL sw_mute_on got=%b exp=110", {audio_mute, busy, src_sel}); end
    r1 = n_rise;
    wait_sig(0, 1'b1, 500, n);
    total++; if (n_rise - r1 !== 1) begin bad++; $display("FAIL sw_flip_after_vs got=%0d exp=1", n_rise - r1); end
    total++; if ({pll_rst, blank} !== 2'b11) begin bad++; $display("FAIL sw_flip_outs got=%b exp=11", {pll_rst, blank}); end
    r1 = n_rise;
    wait_sig(1, 1'b0, 20, n);
    total++; if (n !== 4) begin bad++; $display("FAIL sw_pll_rst_len got=%0d exp=4", n); end
    wait_sig(2, 1'b0, 1000, n);
    total++; if (n_rise - r1 !== 2) begin bad++; $display("FAIL sw_settle_frames got=%0d exp=2", n_rise - r1); end
    wait_sig(4, 1'b0, 400, n);
    total++; if ({src_sel, audio_mute, blank} !== 3'b100) begin bad++; $display("FAIL sw_idle got=%b exp=100", {src_sel, audio_mute, blank}); end
  endtask

  task automatic test_lock_fail();
    int n, np, nr;
    logic prev;
    pll_locked = 1'b0;
    repeat (2) tick();
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL lf_blank_early got=%b exp=0", blank); end
    tick();
    total++; if ({blank, busy, pll_rst} !== 3'b110) begin bad++; $display("FAIL lf_blank_state got=%b exp=110", {blank, busy, pll_rst}); end
    n = 0; np = 0; nr = 0; prev = pll_rst;
    while (busy && n < 400) begin
      tick(); n++;
      if (pll_rst) np++;
      if (pll_rst && !prev) nr++;
      prev = pll_rst;
    end
    total++; if (n !== 209) begin bad++; $display("FAIL lf_fail_time got=%0d exp=209", n); end
    total++; if (np !== 8 || nr !== 2) begin bad++; $display("FAIL lf_pll_pulses got=%0d/%0d exp=8/2", np, nr); end
    total++;
    if ({lock_err, blank, audio_mute, pll_rst, busy, src_sel} !== 6'b111001) begin
      bad++; $display("FAIL lf_fail_outs got=%b exp=111001", {lock_err, blank, audio_mute, pll_rst, busy, src_sel});
    end
    repeat (10) tick();
    pll_locked = 1'b1;
    repeat (5) tick();
    total++; if (lock_err !== 1'b1) begin bad++; $display("FAIL lf_err_held got=%b exp=1", lock_err); end
    tick();
    total++; if ({lock_err, busy, blank} !== 3'b011) begin bad++; $display("FAIL lf_err_clear got=%b exp=011", {lock_err, busy, blank}); end
    wait_sig(4, 1'b0, 1000, n);
    total++; if ({n < 0, blank, audio_mute} !== 3'b000) begin bad++; $display("FAIL lf_recover got=%b exp=000", {n < 0, blank, audio_mute}); end
  endtask

  task automatic test_mute_timeout();
    int n;
    vs_en = 1'b0;
    repeat (3) tick();
    sel_req = 1'b0;
    repeat (3) tick();
    total++; if ({audio_mute, blank} !== 2'b10) begin bad++; $display("FAIL mt_mute_on got=%b exp=10", {audio_mute, blank}); end
    wait_sig(2, 1'b1, 1500, n);
    total++; if (n !== 1000) begin bad++; $display("FAIL mt_timeout_len got=%0d exp=1000", n); end
    total++; if (src_sel !== 1'b1) begin bad++; $display("FAIL mt_src_hold got=%b exp=1", src_sel); end
    vs_en = 1'b1;
    wait_sig(4, 1'b0, 2000, n);
    total++; if ({n < 0, src_sel, blank} !== 3'b000) begin bad++; $display("FAIL mt_done got=%b exp=000", {n < 0, src_sel, blank}); end
  endtask

  task automatic test_settle_drop();
    int n;
    pll_locked = 1'b0;
    wait_sig(1, 1'b1, 20, n);
    wait_sig(1, 1'b0, 10, n);
    wait_sig(1, 1'b1, 120, n);
    total++; if (n !== 100) begin bad++; $display("FAIL sd_lock_timeout got=%0d exp=100", n); end
    wait_sig(1, 1'b0, 10, n);
    pll_locked = 1'b1;
    repeat (12) tick();
    total++; if ({pll_rst, busy, blank} !== 3'b011) begin bad++; $display("FAIL sd_in_settle got=%b exp=011", {pll_rst, busy, blank}); end
    pll_locked = 1'b0; tick(); pll_locked = 1'b1; tick();
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL sd_drop_early got=%b exp=0", pll_rst); end
    tick();
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL sd_drop_rst got=%b exp=1", pll_rst); end
    wait_sig(1, 1'b0, 10, n);
    total++; if (n !== 4) begin bad++; $display("FAIL sd_rst_len got=%0d exp=4", n); end
    repeat (12) tick();
    pll_locked = 1'b0;
    wait_sig(1, 1'b1, 10, n);
    total++; if (n !== 3) begin bad++; $display("FAIL sd_drop2_rst got=%0d exp=3", n); end
    wait_sig(4, 1'b0, 300, n);
    total++; if (n !== 104) begin bad++; $display("FAIL sd_retry_kept got=%0d exp=104", n); end
    total++; if (lock_err !== 1'b1) begin bad++; $display("FAIL sd_lock_err got=%b exp=1", lock_err); end
    pll_locked = 1'b1;
    wait_sig(5, 1'b0, 20, n);
    wait_sig(4, 1'b0, 1000, n);
    total++; if ({n < 0, blank, lock_err} !== 3'b000) begin bad++; $display("FAIL sd_recover got=%b exp=000", {n < 0, blank, lock_err}); end
  endtask

  task automatic test_back_to_back();
    int n;
    sel_req = 1'b1;
    wait_sig(0, 1'b1, 500, n);
    wait_sig(1, 1'b0, 10, n);
    sel_req = 1'b0;
    wait_sig(2, 1'b0, 1000, n);
    total++; if ({n < 0, src_sel, audio_mute} !== 3'b011) begin bad++; $display("FAIL bb_unmute got=%b exp=011", {n < 0, src_sel, audio_mute}); end
    wait_sig(0, 1'b0, 1000, n);
    total++; if ({n < 0, pll_rst, blank} !== 3'b011) begin bad++; $display("FAIL bb_second_switch got=%b exp=011", {n < 0, pll_rst, blank}); end
    wait_sig(4, 1'b0, 1000, n);
    total++; if ({n < 0, src_sel, audio_mute} !== 3'b000) begin bad++; $display("FAIL bb_idle got=%b exp=000", {n < 0, src_sel, audio_mute}); end
  endtask

  task automatic test_reset_mid_settle();
    int n;
    sel_req = 1'b1;
    wait_sig(0, 1'b1, 500, n);
    wait_sig(1, 1'b0, 10, n);
    repeat (12) tick();
    total++; if ({src_sel, pll_rst, busy} !== 3'b101) begin bad++; $display("FAIL rm_in_settle got=%b exp=101", {src_sel, pll_rst, busy}); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({src_sel, pll_rst, blank, audio_mute, busy, lock_err} !== 6'b011110) begin
      bad++; $display("FAIL rm_async_reset got=%b exp=011110", {src_sel, pll_rst, blank, audio_mute, busy, lock_err});
    end
    repeat (3) tick();
    reset_n = 1'b1;
    wait_sig(0, 1'b1, 1500, n);
    wait_sig(4, 1'b0, 1000, n);
    total++; if ({n < 0, src_sel, blank} !== 3'b010) begin bad++; $display("FAIL rm_restart got=%b exp=010", {n < 0, src_sel, blank}); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_switch();
    test_lock_fail();
    test_mute_timeout();
    test_settle_drop();
    test_back_to_back();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
